// File: rtl/prog_mem_pkg.sv
// Shared types, constants and helpers for the loadable instruction memory.
// Default build macros are provided here when the surrounding build does not define them.
`ifndef A_BITS
`define A_BITS 5
`endif
`ifndef NOP
`define NOP 16'h0000
`endif
`ifndef HALT
`define HALT 4'hF
`endif

package prog_mem_pkg;

   typedef enum logic [1:0] {
      PM_IDLE = 2'd0,
      PM_LOAD = 2'd1,
      PM_RUN  = 2'd2
   } pm_state_t;

   // Widest instruction word supported; NOP_WORD is sliced down to I_WIDTH by users.
   localparam int unsigned      MAX_I_W  = 64;
   localparam logic [MAX_I_W-1:0] NOP_WORD = MAX_I_W'(`NOP);
   localparam logic [MAX_I_W-1:0] HALT_OP  = MAX_I_W'(`HALT);

   // True when the opcode field [iw-1 -: ow] of word equals the HALT opcode.
   function automatic logic is_halt(input logic [MAX_I_W-1:0] word,
                                    input int unsigned        iw,
                                    input int unsigned        ow);
      logic [MAX_I_W-1:0] v_mask;
      logic [MAX_I_W-1:0] v_op;
      v_mask = (MAX_I_W'(1) << ow) - MAX_I_W'(1);
      v_op   = (word >> (iw - ow)) & v_mask;
      return (v_op == (HALT_OP & v_mask));
   endfunction

endpackage

// File: rtl/prog_ram.sv
// DEPTH x I_WIDTH program store: one write port and one registered read port.
// Contents are deliberately not reset.
module prog_ram
   import prog_mem_pkg::*;
#(
   parameter int I_WIDTH = 16,
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 5
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_W-1:0]  i_waddr,
   input  logic [I_WIDTH-1:0] i_wdata,
   input  logic               i_re,
   input  logic [ADDR_W-1:0]  i_raddr,
   output logic [I_WIDTH-1:0] o_rdata
);

   logic [I_WIDTH-1:0] r_mem [DEPTH];
   logic [I_WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_ctrl.sv
// Loadable instruction memory: streams a program into RAM, stalls the CPU until
// the load finishes, then serves 1-cycle fetches with NOP padding and HALT detect.
module prog_mem_ctrl
   import prog_mem_pkg::*;
#(
   parameter int I_WIDTH = 16,
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = `A_BITS,
   parameter int OP_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [I_WIDTH-1:0] ld_data,
   input  logic               ld_last,
   input  logic               fetch_en,
   input  logic [ADDR_W-1:0]  pc,
   output logic [I_WIDTH-1:0] instr,
   output logic               instr_valid,
   output logic               cpu_stall,
   output logic               load_done,
   output logic               load_err,
   output logic [ADDR_W:0]    prog_len,
   output logic               halted
);

   localparam logic [I_WIDTH-1:0] NOP_I = NOP_WORD[I_WIDTH-1:0];

   pm_state_t          r_state;
   logic [ADDR_W-1:0]  r_wptr;
   logic [ADDR_W:0]    r_prog_len;
   logic               r_ld_ready;
   logic               r_cpu_stall;
   logic               r_load_done;
   logic               r_load_err;
   logic               r_halted;
   logic               r_instr_valid;
   logic               r_hit;
   logic               r_halt_arm;

   logic               w_hs;
   logic               w_wr_last;
   logic               w_fetch;
   logic               w_in_range;
   logic [I_WIDTH-1:0] w_ram_rdata;
   logic [I_WIDTH-1:0] w_instr;
   logic               w_halt_now;

   // ld_ready is only ever high in LOAD, so it alone qualifies a write.
   assign w_hs       = ld_valid & r_ld_ready;
   assign w_wr_last  = (r_wptr == ADDR_W'(DEPTH - 1));
   assign w_fetch    = (r_state == PM_RUN) & fetch_en;
   assign w_in_range = ({1'b0, pc} < r_prog_len);

   prog_ram #(
      .I_WIDTH (I_WIDTH),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_hs),
      .i_waddr (r_wptr),
      .i_wdata (ld_data),
      .i_re    (w_fetch & w_in_range),
      .i_raddr (pc),
      .o_rdata (w_ram_rdata)
   );

   // Out-of-range fetches leave the RAM register alone and select NOP instead;
   // both r_hit and the RAM register hold when no fetch occurs.
   assign w_instr = r_hit ? w_ram_rdata : NOP_I;

   // A fetch issued together with load_start must not re-raise the cleared flag.
   assign w_halt_now = r_instr_valid & r_halt_arm &
                       is_halt(MAX_I_W'(w_instr), I_WIDTH, OP_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= PM_IDLE;
         r_wptr        <= '0;
         r_prog_len    <= '0;
         r_ld_ready    <= 1'b0;
         r_cpu_stall   <= 1'b1;
         r_load_done   <= 1'b0;
         r_load_err    <= 1'b0;
         r_halted      <= 1'b0;
         r_instr_valid <= 1'b0;
         r_hit         <= 1'b0;
         r_halt_arm    <= 1'b0;
      end else begin
         r_load_done   <= 1'b0;
         r_instr_valid <= w_fetch;
         if (w_fetch) begin
            r_hit      <= w_in_range;
            r_halt_arm <= ~load_start;
         end
         if (w_halt_now) begin
            r_halted <= 1'b1;
         end

         // Entering LOAD comes last so it overrides the sticky halt update above.
         case (r_state)
            PM_IDLE: begin
               if (load_start) begin
                  r_state     <= PM_LOAD;
                  r_wptr      <= '0;
                  r_prog_len  <= '0;
                  r_load_err  <= 1'b0;
                  r_halted    <= 1'b0;
                  r_ld_ready  <= 1'b1;
                  r_cpu_stall <= 1'b1;
               end
            end
            PM_LOAD: begin
               if (w_hs) begin
                  r_wptr     <= r_wptr + ADDR_W'(1);
                  r_prog_len <= r_prog_len + (ADDR_W + 1)'(1);
                  if (ld_last || w_wr_last) begin
                     r_state     <= PM_RUN;
                     r_ld_ready  <= 1'b0;
                     r_cpu_stall <= 1'b0;
                     r_load_done <= 1'b1;
                     r_load_err  <= ~ld_last;
                  end
               end
            end
            PM_RUN: begin
               if (load_start) begin
                  r_state     <= PM_LOAD;
                  r_wptr      <= '0;
                  r_prog_len  <= '0;
                  r_load_err  <= 1'b0;
                  r_halted    <= 1'b0;
                  r_ld_ready  <= 1'b1;
                  r_cpu_stall <= 1'b1;
               end
            end
            default: begin
               r_state     <= PM_IDLE;
               r_ld_ready  <= 1'b0;
               r_cpu_stall <= 1'b1;
            end
         endcase
      end
   end

   assign ld_ready    = r_ld_ready;
   assign instr       = w_instr;
   assign instr_valid = r_instr_valid;
   assign cpu_stall   = r_cpu_stall;
   assign load_done   = r_load_done;
   assign load_err    = r_load_err;
   assign prog_len    = r_prog_len;
   assign halted      = r_halted | w_halt_now;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Scoreboard bench for prog_mem_ctrl: randomized loads and fetches against an
// array-based program model; a negedge monitor pops expected fetch results.
module tb_prog_mem_ctrl;

   localparam int IW    = 16;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int OPW   = 4;
   localparam logic [IW-1:0] NOP_V = 16'h0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic          ld_valid;
   logic          ld_ready;
   logic [IW-1:0] ld_data;
   logic          ld_last;
   logic          fetch_en;
   logic [AW-1:0] pc;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          cpu_stall;
   logic          load_done;
   logic          load_err;
   logic [AW:0]   prog_len;
   logic          halted;

   always #5 clk = ~clk;

   prog_mem_ctrl #(.I_WIDTH(IW), .DEPTH(DEPTH), .ADDR_W(AW), .OP_W(OPW)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .fetch_en(fetch_en), .pc(pc), .instr(instr), .instr_valid(instr_valid),
      .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err),
      .prog_len(prog_len), .halted(halted)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [IW-1:0] exp_q[$];
   logic [IW-1:0] mdl_mem[DEPTH];
   int            mdl_len = 0;
   bit            mdl_run = 1'b0;
   bit            exp_halted = 1'b0;
   bit            mon_en = 1'b0;
   logic [IW-1:0] last_instr = NOP_V;
   logic [IW-1:0] mon_e;

   function automatic bit op_is_halt(input logic [IW-1:0] w);
      return (w[IW-1 -: OPW] == 4'hF);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expected word per instr_valid; otherwise instr must hold.
   always @(negedge clk) begin
      if (mon_en) begin
         if (instr_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 64'(instr_valid), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               if (op_is_halt(mon_e)) exp_halted = 1'b1;
               last_instr = mon_e;
               check("instr", 64'(instr), 64'(mon_e));
            end
         end else begin
            check("instr_hold", 64'(instr), 64'(last_instr));
         end
         check("halted", 64'(halted), 64'(exp_halted));
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      ld_data = '0; fetch_en = 1'b0; pc = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      mdl_len = 0; mdl_run = 1'b0; exp_halted = 1'b0; last_instr = NOP_V;
      @(negedge clk);
      check("rst_cpu_stall", 64'(cpu_stall), 64'd1);
      check("rst_ld_ready", 64'(ld_ready), 64'd0);
      check("rst_instr_valid", 64'(instr_valid), 64'd0);
      check("rst_load_done", 64'(load_done), 64'd0);
      check("rst_load_err", 64'(load_err), 64'd0);
      check("rst_prog_len", 64'(prog_len), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_instr", 64'(instr), 64'(NOP_V));
      mon_en = 1'b1;
      tick();
   endtask

   task automatic fetch(input logic [AW-1:0] a, input bit en);
      fetch_en = en;
      pc = a;
      if (en && mdl_run) exp_q.push_back((int'(a) < mdl_len) ? mdl_mem[a] : NOP_V);
      tick();
   endtask

   // Streams n words; abort_after > 0 stops after that many accepted words.
   task automatic do_load(input int n, input bit use_last, input bit gaps,
                          input int abort_after, input bit halt_end);
      logic [IW-1:0] words[$];
      logic [IW-1:0] w;
      int  sent = 0;
      int  cnt = 0;
      bit  loading = 1'b1;
      bit  done_next = 1'b0;
      bit  exp_err = 1'b0;
      bit  hs;
      for (int i = 0; i < n; i++) begin
         w = IW'($urandom);
         w[IW-1 -: OPW] = (halt_end && i == n - 1) ? 4'hF : 4'($urandom_range(0, 14));
         words.push_back(w);
      end
      fetch_en = 1'b0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      exp_halted = 1'b0;
      mdl_run = 1'b0;
      mdl_len = 0;
      while (sent < n && !(abort_after > 0 && cnt == abort_after)) begin
         ld_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_data    = words[sent];
         ld_last    = use_last && (sent == n - 1);
         load_start = loading && (sent == 2);
         @(negedge clk);
         check("ld_ready", 64'(ld_ready), 64'(loading));
         check("load_done", 64'(load_done), 64'(done_next));
         check("cpu_stall", 64'(cpu_stall), 64'(loading));
         check("prog_len_ld", 64'(prog_len), 64'(cnt));
         done_next = 1'b0;
         hs = ld_valid && loading;
         if (hs) begin
            mdl_mem[cnt] = ld_data;
            cnt++;
            if (ld_last || cnt == DEPTH) begin
               loading = 1'b0;
               done_next = 1'b1;
               exp_err = !ld_last;
               mdl_len = cnt;
               mdl_run = 1'b1;
            end
         end
         if (ld_valid) sent++;
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0; load_start = 1'b0;
      if (abort_after > 0) return;
      @(negedge clk);
      check("load_done_end", 64'(load_done), 64'(done_next));
      check("ld_ready_end", 64'(ld_ready), 64'd0);
      check("cpu_stall_end", 64'(cpu_stall), 64'd0);
      check("prog_len", 64'(prog_len), 64'(cnt));
      check("load_err", 64'(load_err), 64'(exp_err));
      tick();
   endtask

   task automatic drain();
      fetch(0, 1'b0);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      do_reset();

      // Fetch while idle is ignored
      fetch(0, 1'b1);
      @(negedge clk);
      check("idle_fetch_valid", 64'(instr_valid), 64'd0);
      check("idle_cpu_stall", 64'(cpu_stall), 64'd1);
      tick();
      fetch(0, 1'b0);

      // 15-word load, HALT in word 14, sequential fetch then out-of-range
      do_load(15, 1'b1, 1'b0, 0, 1'b1);
      for (int a = 0; a < 15; a++) fetch(AW'(a), 1'b1);
      fetch(AW'(20), 1'b1);
      drain();
      check("halted_after_pc14", 64'(halted), 64'd1);
      for (int i = 0; i < 30; i++) fetch(AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      drain();

      // Reset after 5 of 10 words, then reload with random gaps
      do_load(10, 1'b1, 1'b0, 5, 1'b0);
      do_reset();
      do_load(10, 1'b1, 1'b1, 0, 1'b0);
      check("halted_cleared", 64'(halted), 64'd0);
      for (int a = 0; a < 12; a++) fetch(AW'(a), 1'b1);
      drain();

      // Overflow: 40 words, no ld_last
      do_load(40, 1'b0, 1'b0, 0, 1'b0);
      check("ovf_prog_len", 64'(prog_len), 64'd32);
      check("ovf_load_err", 64'(load_err), 64'd1);
      fetch(AW'(31), 1'b1);
      for (int i = 0; i < 40; i++) fetch(AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      drain();

      // Single-word program that is a HALT
      do_load(1, 1'b1, 1'b1, 0, 1'b1);
      check("one_prog_len", 64'(prog_len), 64'd1);
      fetch(AW'(1), 1'b1);
      fetch(AW'(31), 1'b1);
      fetch(AW'(0), 1'b1);
      drain();
      check("one_halted", 64'(halted), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_mem_ctrl.md
# prog_mem_ctrl

Loadable, parametrised instruction memory for the Harvard pipeline. Replaces the fixed initial-block program store with a RAM loaded at run time over a valid/ready word stream, then serves registered fetches to the IF stage. Holds the CPU stalled until a load completes. Returns NOP beyond the loaded program length, and flags HALT when it is fetched.

## Interface
Parameters:
- `I_WIDTH`, 16: instruction word width.
- `DEPTH`, 32: number of instruction words. Must be ≤ 2**`ADDR_W`.
- `ADDR_W`, `` `A_BITS ``: PC / address width.
- `OP_W`, 4: opcode field width, taken from instruction bits [I_WIDTH-1 -: OP_W].

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_start` in 1: request a new program load (single-cycle pulse).
- `ld_valid` in 1: load word present.
- `ld_ready` out 1: block accepts the load word.
- `ld_data` in I_WIDTH: load word.
- `ld_last` in 1: the current load word is the final word.
- `fetch_en` in 1: IF stage requests the word at `pc`.
- `pc` in ADDR_W: fetch address.
- `instr` out I_WIDTH: fetched instruction (registered).
- `instr_valid` out 1: `instr` is valid this cycle.
- `cpu_stall` out 1: the CPU must not advance.
- `load_done` out 1: one-cycle pulse when a load ends.
- `load_err` out 1: sticky flag; the load overflowed `DEPTH`.
- `prog_len` out ADDR_W+1: number of words loaded.
- `halted` out 1: sticky flag; a HALT word was issued.

## Operation
States: IDLE, LOAD, RUN.
- **Reset** forces:
  - state = IDLE;
  - `ld_ready`, `instr_valid`, `load_done`, `load_err`, `halted` = 0;
  - `cpu_stall` = 1;
  - `prog_len` = 0;
  - `instr` = `` `NOP ``.
  - RAM contents are not reset.
- **IDLE**: `cpu_stall` = 1 and fetches are ignored. `load_start` → LOAD.
- **Entering LOAD**: write pointer = 0, `prog_len` = 0, `load_err` = 0, `halted` = 0.
- **LOAD**:
  - `ld_ready` = 1 and `cpu_stall` = 1.
  - Each cycle with `ld_valid`&&`ld_ready` writes `ld_data` to RAM[wptr], increments wptr and increments `prog_len`.
  - The handshake with `ld_last` → RUN and pulses `load_done`.
  - The handshake that writes word DEPTH-1 without `ld_last` → RUN, pulses `load_done`, and sets `load_err`. `ld_ready` drops the following cycle, and further words are not accepted.
  - `load_start` during LOAD is ignored.
- **RUN**:
  - `cpu_stall` = 0 and `ld_ready` = 0.
  - `fetch_en` at pc < `prog_len` registers RAM[pc] into `instr`.
  - `fetch_en` at pc ≥ `prog_len` registers `` `NOP ``.
  - Either way `instr_valid` = 1 on the next cycle.
  - Without `fetch_en`, `instr` holds its value and `instr_valid` = 0.
- **HALT detect**: when a registered `instr` has opcode == `` `HALT `` opcode, `halted` is set in the same cycle `instr_valid` is asserted. `halted` is sticky. `cpu_stall` is unaffected.
- **RUN + `load_start`**: the same-cycle fetch completes normally, so `instr_valid` is seen next cycle. The state is LOAD next cycle.

## Timing
- Fetch latency: 1 cycle. `pc` is sampled on edge N, and `instr`/`instr_valid` are valid after edge N.
- Load throughput: 1 word per cycle while `ld_valid` is held.
- `cpu_stall` is a registered function of state only, so it falls on the first RUN cycle.
- `load_done` is high for exactly one cycle: the first RUN cycle.
- `rst` during LOAD: the partial program is discarded (`prog_len` = 0) and state = IDLE next cycle. A new `load_start` is required.
- A zero-length program is impossible, since `ld_last` needs a handshake. A 1-word load gives `prog_len` = 1.

## Structure
- Package `prog_mem_pkg` holds:
  - the state enum `pm_state_t`;
  - localparam `NOP_WORD` (`` `NOP `` padded to I_WIDTH);
  - the HALT opcode constant;
  - the function `is_halt(word)`.
- Sub-module `prog_ram`: DEPTH×I_WIDTH array with one write port (we/waddr/wdata) and a registered read port. Write and read never coincide, because the states are exclusive.
- FSM, pointer and flag logic stay in the `prog_mem_ctrl` top.

## Test plan
- **Reset, then idle**: `cpu_stall` = 1, `ld_ready` = 0, and `fetch_en` with pc = 0 gives `instr_valid` = 0.
- **Load of 15 words**: `load_start`, then stream 15 words with `ld_last` on word 14. Required:
  - `load_done` pulses;
  - `prog_len` = 15;
  - fetches at pc 0..14 return the stored words 1 cycle later;
  - the pc 14 fetch sets `halted`.
- **Out-of-range fetch**: after the 15-word load, pc = 20 returns `instr` = `` `NOP `` with `instr_valid` = 1.
- **Overflow**: DEPTH = 32, stream 40 words with no `ld_last`. Required:
  - 32 words are accepted;
  - `ld_ready` = 0 from the cycle after the 32nd word;
  - `load_err` = 1;
  - `prog_len` = 32.
- **Backpressure gaps**: toggle `ld_valid` randomly. Required: words are stored in order and only on handshake cycles.
- **Reset mid-load**: assert `rst` after 5 of 10 words. Required: IDLE, `prog_len` = 0, `cpu_stall` = 1. A reload then succeeds and `halted` is cleared.
